relu_maxpool_2x2: RTL and testbench
===================================

Name: relu_maxpool_2x2

Overview:
- Downstream consumer of the single-layer convolution stage.
- Walks that stage's 16-bit result buffer through its ReadReg/ReadData read port, one 2x2 window at a time, non-overlapping, stride 2.
- Applies ReLU and 2x2 max pooling to each window.
- Streams each pooled value out with a valid/ready handshake, tagged with its output index; this feeds the next layer or result storage.

Parameters:
- IMG_W, 32, feature-map width in pixels (must be even).
- IMG_H, 32, feature-map height in pixels (must be even).
- DATA_W, 16, signed pixel width; equals the conv stage's ReadData width.
- ADDR_W, 10, conv result-buffer address width (IMG_W*IMG_H <= 2^ADDR_W).
- OUT_ADDR_W, 8, pooled output index width ((IMG_W/2)*(IMG_H/2) <= 2^OUT_ADDR_W).

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- start, input, 1, one-cycle pulse that begins a full-map pass; ignored unless idle.
- ReadReg, output, ADDR_W, registered address to the conv result buffer.
- ReadData, input, DATA_W, signed data; combinational from ReadReg, sampled at the edge ending the cycle the address is driven.
- out_valid, output, 1, pooled result available.
- out_ready, input, 1, downstream accepts when out_valid && out_ready.
- out_data, output, DATA_W, pooled value (always >= 0).
- out_addr, output, OUT_ADDR_W, pooled index = r*(IMG_W/2)+c.
- busy, output, 1, high from the cycle after start until done.
- done, output, 1, one-cycle pulse after the final accepted output.

Behaviour:
- Reset values: ReadReg=0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0. FSM goes to IDLE; window counters r and c are cleared.
- FSM states: IDLE, RD0, RD1, RD2, RD3, EMIT, FIN.
- IDLE: on start, go to RD0 with r=c=0 and drive ReadReg with the (0,0) pixel address.
- RDk: drive the address of window pixel k; next state RD(k+1), then EMIT after RD3.
  - Pixel order: k0=(2r,2c), k1=(2r,2c+1), k2=(2r+1,2c), k3=(2r+1,2c+1).
  - Address = row*IMG_W + col.
  - Each sample is folded into a running max register: loaded with the k0 sample, updated on k1..k3.
- EMIT: out_valid=1; out_data=max(runmax,0); out_addr=r*(IMG_W/2)+c.
  - out_data and out_addr are held stable until the handshake.
  - On handshake, c increments; at c wrap, c=0 and r increments.
  - If the accepted window was the last (r=IMG_H/2-1, c=IMG_W/2-1), go to FIN; otherwise go to RD0 and drop out_valid.
- FIN: done=1 for one cycle, busy=0, then IDLE.
- Throughput: 5 cycles per window with out_ready held high. First out_valid appears 5 cycles after the start edge.
- Arithmetic: signed DATA_W compare. ReLU is applied after the max (equivalent to max of ReLUs). No saturation is needed.
- A start pulse while busy is ignored; the pass is not restarted.
- reset asserted mid-pass aborts immediately to reset values. No done pulse is produced, and no partial output is held.
- out_ready is ignored when out_valid=0.

Optional Feature:
- Macro: POOL_AVG_EN.
- Defined: average pooling. The 4 samples are summed in a DATA_W+2-bit signed accumulator, arithmetic-shifted right by 2 (floor), ReLU is applied, and the result is truncated to DATA_W. Timing is unchanged.
- Undefined: max pooling as described above.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, FSM state encoding constants, and a pixel-address helper function (row*IMG_W+col).
- One natural sub-module: pool_accum, which holds the running max or sum plus the ReLU output stage. It has load, accumulate and result signals, and the POOL_AVG_EN selection lives inside it.
- The FSM and address generation stay in the top level.

Test Plan:
- Buffer model mem[i]=i, out_ready=1, start -> 256 outputs. addr0=33, addr1=35, addr255=1023; done pulses once; busy spans the whole pass.
- Window values -5, 7, -100, 3 (others 0) -> out_data=7.
- All-negative window (-1, -2, -3, -4) -> out_data=0.
- out_ready=0 for 3 cycles in EMIT -> out_valid stays 1 with out_data/out_addr unchanged; the next window's reads do not start until the handshake.
- reset at output 10 of a pass -> next cycle all outputs are at reset values, no done pulse. A new start then restarts at out_addr 0.
- With POOL_AVG_EN, window 4, 8, 12, 16 -> 10.
- With POOL_AVG_EN, window -5, 7, -100, 3 -> 0 (sum -95, shifted -24, ReLU gives 0).
- A start pulse issued mid-pass -> ignored; the output count remains 256.

Source files
------------

// File: rtl/relu_maxpool_2x2_pkg.sv
// Shared definitions for the ReLU + 2x2 pooling stage: default widths and
// geometry, FSM state encoding, and the pixel-address helper.
package relu_maxpool_2x2_pkg;

  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_ADDR_W     = 10;
  localparam int unsigned DEF_OUT_ADDR_W = 8;
  localparam int unsigned DEF_IMG_W      = 32;
  localparam int unsigned DEF_IMG_H      = 32;

  // One read state per window pixel, then the output handshake, then done.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRd0  = 3'd1,
    StRd1  = 3'd2,
    StRd2  = 3'd3,
    StRd3  = 3'd4,
    StEmit = 3'd5,
    StFin  = 3'd6
  } state_e;

  // Linear address of a pixel in the row-major conv result buffer.
  function automatic int unsigned pix_addr(input int unsigned row, input int unsigned col,
                                           input int unsigned img_w);
    return row * img_w + col;
  endfunction

endpackage

// File: rtl/relu_maxpool_2x2_pool_accum.sv
// Window accumulator with ReLU output stage.
// POOL_AVG_EN defined: 4-sample sum, floor divide by 4, ReLU.
// POOL_AVG_EN undefined: running signed max, ReLU.
module relu_maxpool_2x2_pool_accum
  import relu_maxpool_2x2_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_load,
  input  logic                     i_accum,
  input  logic signed [DATA_W-1:0] i_sample,
  output logic        [DATA_W-1:0] o_result
);

`ifdef POOL_AVG_EN
  logic signed [DATA_W+1:0] r_sum;
  logic signed [DATA_W+1:0] w_avg;

  // Running sum: first sample loads, the other three add.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sum <= '0;
    end else if (i_load) begin
      r_sum <= (DATA_W + 2)'(i_sample);
    end else if (i_accum) begin
      r_sum <= r_sum + (DATA_W + 2)'(i_sample);
    end
  end

  // Arithmetic shift floors the average; negative results clamp to zero.
  always_comb begin
    w_avg    = r_sum >>> 2;
    o_result = w_avg[DATA_W+1] ? '0 : w_avg[DATA_W-1:0];
  end
`else
  logic signed [DATA_W-1:0] r_max;

  // Running max: first sample loads, the other three compete.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_max <= '0;
    end else if (i_load) begin
      r_max <= i_sample;
    end else if (i_accum && (i_sample > r_max)) begin
      r_max <= i_sample;
    end
  end

  // ReLU after the max equals the max of the ReLUs.
  always_comb begin
    o_result = r_max[DATA_W-1] ? '0 : r_max;
  end
`endif

endmodule

// File: rtl/relu_maxpool_2x2.sv
// ReLU + non-overlapping 2x2 pooling over the conv stage's result buffer.
// Reads each window's four pixels through ReadReg/ReadData, then offers the
// pooled value on a valid/ready port tagged with its output index.
// Optional POOL_AVG_EN selects average pooling instead of max pooling.
module relu_maxpool_2x2
  import relu_maxpool_2x2_pkg::*;
#(
  parameter int unsigned IMG_W      = DEF_IMG_W,
  parameter int unsigned IMG_H      = DEF_IMG_H,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned OUT_ADDR_W = DEF_OUT_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic        [ADDR_W-1:0] ReadReg,
  input  logic signed [DATA_W-1:0] ReadData,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [DATA_W-1:0] out_data,
  output logic    [OUT_ADDR_W-1:0] out_addr,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned WIN_W = IMG_W / 2;
  localparam int unsigned WIN_H = IMG_H / 2;
  localparam int unsigned ROW_W = (WIN_H > 1) ? $clog2(WIN_H) : 1;
  localparam int unsigned COL_W = (WIN_W > 1) ? $clog2(WIN_W) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(WIN_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIN_W - 1);

  state_e            r_state, w_state_d;
  logic [ROW_W-1:0]  r_row, w_row_d;
  logic [COL_W-1:0]  r_col, w_col_d;
  logic [ADDR_W-1:0] r_read_reg, w_read_reg_d;
  logic              w_load, w_accum, w_last;
  logic [DATA_W-1:0] w_result;

  assign w_last = (r_row == ROW_LAST) && (r_col == COL_LAST);

  relu_maxpool_2x2_pool_accum #(
    .DATA_W (DATA_W)
  ) u_pool_accum (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_load   (w_load),
    .i_accum  (w_accum),
    .i_sample (ReadData),
    .o_result (w_result)
  );

  // State, window counters and read address register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_row      <= '0;
      r_col      <= '0;
      r_read_reg <= '0;
    end else begin
      r_state    <= w_state_d;
      r_row      <= w_row_d;
      r_col      <= w_col_d;
      r_read_reg <= w_read_reg_d;
    end
  end

  // Next state, next window position and next buffer address. ReadData for
  // the address driven in RDk is folded into the accumulator at the end of RDk.
  always_comb begin
    w_state_d    = r_state;
    w_row_d      = r_row;
    w_col_d      = r_col;
    w_read_reg_d = r_read_reg;
    w_load       = 1'b0;
    w_accum      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d    = StRd0;
          w_row_d      = '0;
          w_col_d      = '0;
          w_read_reg_d = '0;
        end
      end
      StRd0: begin
        w_load       = 1'b1;
        w_state_d    = StRd1;
        w_read_reg_d = ADDR_W'(pix_addr(2 * 32'(r_row), 2 * 32'(r_col) + 1, IMG_W));
      end
      StRd1: begin
        w_accum      = 1'b1;
        w_state_d    = StRd2;
        w_read_reg_d = ADDR_W'(pix_addr(2 * 32'(r_row) + 1, 2 * 32'(r_col), IMG_W));
      end
      StRd2: begin
        w_accum      = 1'b1;
        w_state_d    = StRd3;
        w_read_reg_d = ADDR_W'(pix_addr(2 * 32'(r_row) + 1, 2 * 32'(r_col) + 1, IMG_W));
      end
      StRd3: begin
        w_accum   = 1'b1;
        w_state_d = StEmit;
      end
      StEmit: begin
        if (out_ready) begin
          if (w_last) begin
            w_state_d = StFin;
            w_row_d   = '0;
            w_col_d   = '0;
          end else begin
            if (r_col == COL_LAST) begin
              w_col_d = '0;
              w_row_d = r_row + ROW_W'(1);
            end else begin
              w_col_d = r_col + COL_W'(1);
            end
            w_state_d    = StRd0;
            w_read_reg_d = ADDR_W'(pix_addr(2 * 32'(w_row_d), 2 * 32'(w_col_d), IMG_W));
          end
        end
      end
      StFin: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Outputs decode directly from registered state; accumulator is idle in EMIT,
  // so data and index stay put until the handshake.
  always_comb begin
    ReadReg   = r_read_reg;
    out_valid = (r_state == StEmit);
    out_data  = out_valid ? w_result : '0;
    out_addr  = OUT_ADDR_W'(32'(r_row) * WIN_W + 32'(r_col));
    busy      = (r_state != StIdle) && (r_state != StFin);
    done      = (r_state == StFin);
  end

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Self-checking bench for relu_maxpool_2x2: buffer model, randomized stimulus
// and backpressure, compared against a window-level reference computation.
module tb_relu_maxpool_2x2;

  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [9:0]  ReadReg;
  logic signed [15:0] ReadData;
  logic        out_valid, busy, done;
  logic [15:0] out_data;
  logic [7:0]  out_addr;

  logic signed [15:0] mem [0:1023];
  int n_checks = 0;
  int n_fail   = 0;
  int got [0:255];

  always #5 clk = ~clk;

  assign ReadData = mem[ReadReg];

  relu_maxpool_2x2 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ReadReg   (ReadReg),
    .ReadData  (ReadData),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .busy      (busy),
    .done      (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: pooled value of window idx straight from the buffer contents.
  function automatic int exp_val(input int idx);
    int r, c, m;
    int p [4];
    r = idx / 16;
    c = idx % 16;
    p[0] = int'(mem[(2 * r) * 32 + 2 * c]);
    p[1] = int'(mem[(2 * r) * 32 + 2 * c + 1]);
    p[2] = int'(mem[(2 * r + 1) * 32 + 2 * c]);
    p[3] = int'(mem[(2 * r + 1) * 32 + 2 * c + 1]);
`ifdef POOL_AVG_EN
    m = (p[0] + p[1] + p[2] + p[3]) >>> 2;
`else
    m = p[0];
    for (int k = 1; k < 4; k++) if (p[k] > m) m = p[k];
`endif
    return (m < 0) ? 0 : m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_readreg"}, 32'(ReadReg), 0);
    check_eq({tag, "_valid"}, 32'(out_valid), 0);
    check_eq({tag, "_data"}, 32'(out_data), 0);
    check_eq({tag, "_addr"}, 32'(out_addr), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
  endtask

  // One full-map pass with optional stall, random ready, stray start or abort.
  task automatic run_pass(input int stall_at, input bit rnd_ready, input bit mid_start,
                          input int abort_at);
    int n_out = 0, done_cnt = 0, busy_bad = 0, stall_cnt = 0, extra_done = 0;
    bit prev_stall = 0, finished = 0, aborted = 0;
    logic [15:0] pd;
    logic [7:0]  pa;
    logic [9:0]  pr;
    pd = '0; pa = '0; pr = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      start     = mid_start && (cyc == 100);
      if (stall_at >= 0 && out_valid && n_out == stall_at && stall_cnt < 3) begin
        out_ready = 1'b0;
        stall_cnt++;
      end
      if (prev_stall) begin
        check_eq("stall_valid", 32'(out_valid), 1);
        check_eq("stall_data", 32'(out_data), 32'(pd));
        check_eq("stall_addr", 32'(out_addr), 32'(pa));
        check_eq("stall_readreg", 32'(ReadReg), 32'(pr));
      end
      if (abort_at >= 0 && out_valid && n_out == abort_at) begin
        out_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("abort");
        for (int i = 0; i < 8; i++) begin
          if (done) extra_done++;
          tick();
        end
        check_eq("abort_no_done", extra_done, 0);
        check_eq("abort_idle_busy", 32'(busy), 0);
        aborted  = 1;
        finished = 1;
      end else begin
        if (done) begin
          done_cnt++;
          check_eq("busy_at_done", 32'(busy), 0);
          finished = 1;
        end else if (!busy) begin
          busy_bad++;
        end
        if (out_valid && out_ready) begin
          check_eq("out_data", 32'(out_data), exp_val(n_out));
          check_eq("out_addr", 32'(out_addr), n_out);
          if (n_out < 256) got[n_out] = int'(out_data);
          n_out++;
        end
        prev_stall = out_valid && !out_ready;
        pd = out_data;
        pa = out_addr;
        pr = ReadReg;
        if (!finished) tick();
      end
    end
    start = 1'b0;
    if (!aborted) begin
      check_eq("pass_finished", 32'(finished), 1);
      check_eq("out_count", n_out, 256);
      check_eq("busy_span", busy_bad, 0);
      for (int i = 0; i < 4; i++) begin
        tick();
        if (done) done_cnt++;
      end
      check_eq("done_pulses", done_cnt, 1);
      if (stall_at >= 0) check_eq("stall_cycles", stall_cnt, 3);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Ramp buffer, ready always high, stray start mid-pass.
    run_pass(-1, 1'b0, 1'b1, -1);
`ifdef POOL_AVG_EN
    check_eq("ramp_first", got[0], 16);
    check_eq("ramp_second", got[1], 18);
    check_eq("ramp_last", got[255], 1006);
`else
    check_eq("ramp_first", got[0], 33);
    check_eq("ramp_second", got[1], 35);
    check_eq("ramp_last", got[255], 1023);
`endif

    // Random buffer with hand-placed windows, random backpressure, 3-cycle stall.
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[0] = -16'sd5;  mem[1] = 16'sd7;  mem[32] = -16'sd100; mem[33] = 16'sd3;
    mem[2] = -16'sd1;  mem[3] = -16'sd2; mem[34] = -16'sd3;   mem[35] = -16'sd4;
    mem[4] = 16'sd4;   mem[5] = 16'sd8;  mem[36] = 16'sd12;   mem[37] = 16'sd16;
    run_pass(3, 1'b1, 1'b0, -1);
`ifdef POOL_AVG_EN
    check_eq("mixed_window", got[0], 0);
    check_eq("negative_window", got[1], 0);
    check_eq("ramp_window", got[2], 10);
`else
    check_eq("mixed_window", got[0], 7);
    check_eq("negative_window", got[1], 0);
    check_eq("ramp_window", got[2], 16);
`endif

    // Abort at output 10, then a clean pass restarting from index 0.
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    run_pass(-1, 1'b0, 1'b0, 10);
    run_pass(-1, 1'b1, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
